// File: rtl/s832_bist_pkg.sv
// Shared types, widths and polynomial taps for the s832 BIST sequencer.
// Also provides the core-output packing order used on CORE_RESP.
package s832_bist_pkg;

  localparam int VEC_W  = 17;
  localparam int RESP_W = 19;
  localparam int CNT_W  = 16;

  // Feedback taps: LFSR uses bits 16 and 13, MISR uses bits 18, 5, 1 and 0.
  localparam logic [VEC_W-1:0]  LFSR_TAPS = 17'h12000;
  localparam logic [RESP_W-1:0] MISR_TAPS = 19'h40023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] cur);
    return {cur[VEC_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [RESP_W-1:0] pack_resp(
    input logic g327, input logic g325, input logic g322, input logic g315,
    input logic g312, input logic g310, input logic g302, input logic g300,
    input logic g298, input logic g296, input logic g292, input logic g290,
    input logic g288, input logic g55,  input logic g53,  input logic g49,
    input logic g47,  input logic g45,  input logic g43
  );
    return {g327, g325, g322, g315, g312, g310, g302, g300, g298, g296,
            g292, g290, g288, g55, g53, g49, g47, g45, g43};
  endfunction

endpackage

// File: rtl/s832_misr.sv
// Parallel-input multiple-input signature register with clear and enable.
// sig_next exposes the value the register will take on an enabled edge.
module s832_misr
  import s832_bist_pkg::*;
#(
  parameter int          W    = RESP_W,
  parameter logic [W-1:0] TAPS = MISR_TAPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig,
  output logic [W-1:0] sig_next
);

  // Shift with polynomial feedback, then fold in the parallel response.
  always_comb begin
    sig_next = {sig[W-2:0], ^(sig & TAPS)} ^ din;
  end

  // Signature register; clear has priority over compaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/s832_bist_ctrl.sv
// BIST sequencer for the s832 core: clear, apply N_VEC LFSR vectors,
// compact responses into a MISR and compare against GOLDEN.
module s832_bist_ctrl
  import s832_bist_pkg::*;
#(
  parameter int                N_VEC  = 256,
  parameter logic [VEC_W-1:0]  SEED   = 17'h1ACE5,
  parameter logic [RESP_W-1:0] GOLDEN = 19'h00000
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  output logic [VEC_W-1:0]  CORE_VEC,
  output logic              CORE_G18,
  input  logic [RESP_W-1:0] CORE_RESP,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [RESP_W-1:0] SIGNATURE
);

  generate
    if (SEED == 17'h00000) begin : g_bad_seed
      $error("s832_bist_ctrl: SEED must be nonzero");
    end
    if ((N_VEC < 1) || (N_VEC > 65535)) begin : g_bad_nvec
      $error("s832_bist_ctrl: N_VEC must be in 1..65535");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_VEC - 1);

  state_t              state_r;
  logic [VEC_W-1:0]    lfsr_r;
  logic [CNT_W-1:0]    count_r;
  logic                start_run_s;
  logic                misr_en_s;
  logic [RESP_W-1:0]   misr_sig_s;
  logic [RESP_W-1:0]   misr_next_s;

  // Run start and compaction enables decoded from the current state.
  always_comb begin
    start_run_s = 1'b0;
    misr_en_s   = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      start_run_s = START;
    end else if (state_r == ST_APPLY) begin
      misr_en_s = 1'b1;
    end else begin
      start_run_s = 1'b0;
      misr_en_s   = 1'b0;
    end
  end

  s832_misr #(
    .W    (RESP_W),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk      (CK),
    .rst      (RST),
    .clr      (start_run_s),
    .en       (misr_en_s),
    .din      (CORE_RESP),
    .sig      (misr_sig_s),
    .sig_next (misr_next_s)
  );

  // Sequencer FSM with registered core drive and status outputs.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= SEED;
      count_r   <= '0;
      CORE_VEC  <= '0;
      CORE_G18  <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      SIGNATURE <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_r  <= ST_CLR;
            lfsr_r   <= SEED;
            count_r  <= '0;
            PASS     <= 1'b0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            CORE_G18 <= 1'b1;
            CORE_VEC <= '0;
          end else begin
            state_r  <= state_r;
          end
        end
        ST_CLR: begin
          // The core saw G18=1 on this edge; start presenting the seed vector.
          state_r  <= ST_APPLY;
          CORE_G18 <= 1'b0;
          CORE_VEC <= lfsr_r;
        end
        ST_APPLY: begin
          lfsr_r  <= lfsr_step(lfsr_r);
          count_r <= count_r + 16'd1;
          if (count_r == LAST_CNT) begin
            state_r   <= ST_DONE;
            SIGNATURE <= misr_next_s;
            PASS      <= (misr_next_s == GOLDEN);
            CORE_G18  <= 1'b1;
            CORE_VEC  <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
          end else begin
            CORE_VEC  <= lfsr_step(lfsr_r);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          CORE_G18 <= 1'b1;
          CORE_VEC <= '0;
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/s832_bist_ctrl.md
# s832_bist_ctrl

Built-in self-test sequencer for the s832 sequential core. It drives the core into its all-zero state through the core's G18 clear input. It then applies a programmable number of pseudo-random input vectors from a 17-bit LFSR and compacts the core's 19 outputs into a MISR signature. At the end it compares the signature against a golden value. It sits beside an s832 instance, owns all of its primary inputs, and shares the core clock.

## Interface
Parameters:
- N_VEC, 256: vectors applied per run; legal range 1..65535.
- SEED, 17'h1ACE5: LFSR start value; must be nonzero (elaboration error otherwise).
- GOLDEN, 19'h00000: expected final signature.

Ports:
- CK  in  1  clock; also clocks the s832 core.
- RST  in  1  synchronous, active-high reset.
- START  in  1  run request; sampled in IDLE and DONE only, ignored otherwise.
- CORE_VEC  out  17  core inputs; bit i drives Gi (G0..G16).
- CORE_G18  out  1  core clear input.
- CORE_RESP  in  19  core outputs, packed {G327,G325,G322,G315,G312,G310,G302,G300,G298,G296,G292,G290,G288,G55,G53,G49,G47,G45,G43}.
- BUSY  out  1  high in CLR and APPLY.
- DONE  out  1  high in DONE.
- PASS  out  1  valid while DONE is high; 1 when the signature equals GOLDEN.
- SIGNATURE  out  19  final MISR value; held until the next run starts.

## Operation
- FSM states: IDLE, CLR, APPLY, DONE.
- IDLE
  - CORE_G18=1, CORE_VEC=0.
  - START -> CLR. On this edge: LFSR<=SEED, MISR<=0, count<=0, PASS<=0.
- CLR
  - CORE_G18=1 for exactly one edge, which zeroes all five core flip-flops.
  - Next state is always APPLY.
- APPLY
  - CORE_G18=0, CORE_VEC=LFSR.
  - Every edge: MISR<=({MISR[17:0], MISR[18]^MISR[5]^MISR[1]^MISR[0]}) ^ CORE_RESP.
  - Every edge: LFSR<={LFSR[15:0], LFSR[16]^LFSR[13]}.
  - Every edge: count<=count+1.
  - When count==N_VEC-1 on an edge: go to DONE, SIGNATURE<=MISR_next, PASS<=(MISR_next==GOLDEN).
- DONE
  - CORE_G18=1, CORE_VEC=0; outputs are held.
  - START -> CLR, which begins a new run with identical reset-of-run actions.
- CORE_RESP is sampled on the same edge that retires the vector applied in that cycle. The core outputs are combinational on current state plus inputs, so there is no pipeline offset.
- RST in any state, including mid-APPLY, returns the block to IDLE on the next edge. The partial signature is discarded.
- Reset values: state=IDLE, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, CORE_VEC=0, CORE_G18=1, LFSR=SEED, MISR=0, count=0.
- count is 16 bits and never wraps, because N_VEC ≤ 65535.

## Timing
- START is sampled at edge k.
- BUSY=1 from after edge k.
- CLR covers cycle k..k+1.
- The first vector (SEED) is visible after edge k+1.
- The last vector is retired at edge k+N_VEC+1.
- DONE=1 and BUSY=0 from after edge k+N_VEC+1, so total run latency is N_VEC+2 cycles.
- CORE_VEC and CORE_G18 are registered outputs with no combinational path from START.
- START held high continuously: restarts on the edge after DONE is reached; DONE lasts one cycle.
- RST and START on the same edge: RST wins.

## Structure
- Shared package s832_bist_pkg contains:
  - state enum;
  - widths VEC_W=17, RESP_W=19, CNT_W=16;
  - LFSR and MISR tap constants;
  - a RESP pack function naming the output order above.
- One sub-module: s832_misr, a 19-bit parallel-input signature register with clear/enable, reusable for other ISCAS-89 wrappers.
- The LFSR and counter stay inline.

## Test plan
- Reset value: RST for 2 cycles, then idle. Required: CORE_G18=1, CORE_VEC=0, BUSY=DONE=PASS=0, SIGNATURE=0.
- LFSR sequence: SEED=17'h00001, N_VEC=3. Required CORE_VEC sequence is 17'h00001, 17'h00002, 17'h00004. DONE rises exactly 5 cycles after the START edge.
- MISR arithmetic: CORE_RESP forced to 19'h00001, N_VEC=2. Required SIGNATURE=19'h00002. With GOLDEN=19'h00002, PASS=1; with GOLDEN=0, PASS=0.
- Zero response: CORE_RESP=0, N_VEC=256, GOLDEN=0. Required SIGNATURE=0, PASS=1, DONE asserted after 258 cycles.
- Abort: RST asserted in APPLY at count=10. Next cycle: IDLE, BUSY=0, SIGNATURE=0. A following START runs a full sequence and matches the result of an uninterrupted run.
- Live core, START ignored while busy: connect a real s832 and pulse START during APPLY. The pulse has no effect; the signature equals the reference-model signature for the same SEED and N_VEC.
